beam_block_serializer: RTL and testbench

//  Inverse of the 4-block beam collector. Accepts frames of wide beam words (4 lanes x DATA_WIDTH per beat)

---
 rtl/beam_pkg.sv | 10 +
 rtl/sdp_ram.sv | 27 ++
 rtl/beam_block_serializer.sv | 179 +++++++++++++++++
 tb/tb_beam_block_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// Shared types for the beam block serializer.
package beam_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {IDLE, RD_BLK, GAP, RELEASE} ser_state_t;

  typedef logic [1:0] blk_idx_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with a configurable read pipeline (data valid READ_LATENCY cycles after i_re).
module sdp_ram #(
  parameter int unsigned DW           = 64,
  parameter int unsigned AW           = 7,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q  [READ_LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rd_q[0] <= mem_q[i_raddr];
    for (int i = 1; i < int'(READ_LATENCY); i++) rd_q[i] <= rd_q[i-1];
  end

  assign o_rdata = rd_q[READ_LATENCY-1];

endmodule

// File: rtl/beam_block_serializer.sv
// Buffers wide 4-lane frames in ping-pong banks and replays them as 4 narrow blocks separated by idle gaps.
module beam_block_serializer
  import beam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned BLOCK_GAP    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_vld,
  input  logic                        i_last,
  input  logic [LANES*DATA_WIDTH-1:0] i_data,
  output logic                        o_ready,
  output logic                        o_overflow,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [ADDR_WIDTH-1:0]       o_addr,
  output logic                        o_vld,
  output logic                        o_tvalid,
  output blk_idx_t                    o_blk_idx,
  output logic                        o_eob,
  output logic                        o_eof
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (BLOCK_GAP > 1) ? $clog2(BLOCK_GAP) : 1;
  localparam int unsigned PW = AW + 5;
  localparam logic [AW-1:0] PTR_MAX = '1;

  logic                 wr_bank_q, wr_bank_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]           full_q, full_d;
  logic [1:0][LW-1:0]   len_q, len_d;
  logic                 wr_en_c, wr_close_c;

  ser_state_t           state_q, state_d;
  blk_idx_t             blk_q, blk_d;
  logic [AW-1:0]        raddr_q, raddr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 rd_issue_c, rd_last_c, release_c;

  logic [READ_LATENCY-1:0][PW-1:0] pipe_q;
  logic [PW-1:0]                   stage_c;
  logic [DW-1:0]                   lane_rdata [LANES];

  assign o_ready    = ~full_q[wr_bank_q];
  assign o_overflow = i_vld & ~o_ready;
  assign wr_en_c    = i_vld & o_ready;
  assign wr_close_c = wr_en_c & (i_last | (wr_ptr_q == PTR_MAX));

  // Write side: bank/pointer advance, frame close and bank occupancy.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    len_d     = len_q;
    if (release_c) full_d[rd_bank_q] = 1'b0;
    if (wr_en_c) begin
      if (wr_close_c) begin
        len_d[wr_bank_q]  = LW'(wr_ptr_q) + LW'(1);
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_ptr_d          = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  assign rd_last_c = (LW'(raddr_q) + LW'(1)) == len_q[rd_bank_q];

  // Read FSM: lane blocks in order, gap between blocks, release the bank after lane 3.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    raddr_d    = raddr_q;
    gap_d      = gap_q;
    rd_bank_d  = rd_bank_q;
    rd_issue_c = 1'b0;
    release_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = RD_BLK;
          blk_d   = '0;
          raddr_d = '0;
        end
      end
      RD_BLK: begin
        rd_issue_c = 1'b1;
        if (rd_last_c) begin
          if (blk_q == blk_idx_t'(LANES - 1)) begin
            state_d = RELEASE;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          raddr_d = raddr_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(BLOCK_GAP - 1)) begin
          state_d = RD_BLK;
          blk_d   = blk_q + 1'b1;
          raddr_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RELEASE: begin
        release_c = 1'b1;
        rd_bank_d = ~rd_bank_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stage_c = rd_issue_c ?
    {1'b1, rd_last_c, rd_last_c & (blk_q == blk_idx_t'(LANES - 1)), blk_q, raddr_q} : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      full_q    <= '0;
      len_q     <= '0;
      state_q   <= IDLE;
      blk_q     <= '0;
      raddr_q   <= '0;
      gap_q     <= '0;
      rd_bank_q <= 1'b0;
      pipe_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
      len_q     <= len_d;
      state_q   <= state_d;
      blk_q     <= blk_d;
      raddr_q   <= raddr_d;
      gap_q     <= gap_d;
      rd_bank_q <= rd_bank_d;
      pipe_q[0] <= stage_c;
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // One RAM per lane; only the lane of the current block is read.
  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    sdp_ram #(
      .DW           (DW),
      .AW           (LW),
      .READ_LATENCY (READ_LATENCY)
    ) u_ram (
      .i_clk   (i_clk),
      .i_we    (wr_en_c),
      .i_waddr ({wr_bank_q, wr_ptr_q}),
      .i_wdata (i_data[k*DW +: DW]),
      .i_re    (rd_issue_c && (blk_q == blk_idx_t'(k))),
      .i_raddr ({rd_bank_q, raddr_q}),
      .o_rdata (lane_rdata[k])
    );
  end

  assign o_vld     = pipe_q[READ_LATENCY-1][PW-1];
  assign o_eob     = pipe_q[READ_LATENCY-1][PW-2];
  assign o_eof     = pipe_q[READ_LATENCY-1][PW-3];
  assign o_blk_idx = pipe_q[READ_LATENCY-1][AW+1:AW];
  assign o_addr    = pipe_q[READ_LATENCY-1][AW-1:0];
  assign o_tvalid  = o_vld;
  assign o_data    = o_vld ? lane_rdata[o_blk_idx] : '0;

endmodule

// File: tb/tb_beam_block_serializer.sv
// Directed + random bench for beam_block_serializer with an expected-word scoreboard.
module tb_beam_block_serializer;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int RL = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [1:0]    blk;
    logic          eob;
    logic          eof;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_vld = 1'b0;
  logic          i_last = 1'b0;
  logic [4*DW-1:0] i_data = '0;
  logic          o_ready, o_overflow, o_vld, o_tvalid, o_eob, o_eof;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic [1:0]    o_blk_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_cnt = 0;
  int fall_cnt = 0;
  logic prev_tv = 1'b0;
  exp_t sb[$];
  logic [DW-1:0] fw [4][64];

  beam_block_serializer dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_vld      (i_vld),
    .i_last     (i_last),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_overflow (o_overflow),
    .o_data     (o_data),
    .o_addr     (o_addr),
    .o_vld      (o_vld),
    .o_tvalid   (o_tvalid),
    .o_blk_idx  (o_blk_idx),
    .o_eob      (o_eob),
    .o_eof      (o_eof)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Output monitor: envelope, scoreboard pop, overflow and tvalid-fall counting.
  always @(negedge i_clk) begin
    exp_t e;
    check("tvalid_eq_vld", 128'(o_tvalid), 128'(o_vld));
    if (o_vld === 1'b1) begin
      check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_word", 128'({o_data, o_addr, o_blk_idx, o_eob, o_eof}), 128'(e));
      end
    end
    if (o_overflow === 1'b1) ovf_cnt++;
    if (prev_tv === 1'b1 && o_tvalid === 1'b0) fall_cnt++;
    prev_tv = o_tvalid;
  end

  task automatic build_frame(input int fid, input bit rnd);
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 64; n++)
        fw[k][n] = rnd ? {$urandom, $urandom} : {16'(fid), 16'(k), 32'(n)};
  endtask

  task automatic send_frame(input int len, input bit use_last, input int gap_max, input bit wait_rdy);
    exp_t e;
    for (int n = 0; n < len; n++) begin
      if (wait_rdy) begin
        int t = 0;
        while (o_ready !== 1'b1 && t < 2000) begin tick(); t++; end
        if (t >= 2000) check("ready_timeout", 128'(o_ready), 128'(1));
      end
      i_vld  = 1'b1;
      i_last = use_last && (n == len - 1);
      i_data = {fw[3][n], fw[2][n], fw[1][n], fw[0][n]};
      tick();
      i_vld  = 1'b0;
      i_last = 1'b0;
      if (n == len - 1) begin
        for (int b = 0; b < 4; b++)
          for (int a = 0; a < len; a++) begin
            e.data = fw[b][a];
            e.addr = AW'(a);
            e.blk  = 2'(b);
            e.eob  = (a == len - 1);
            e.eof  = (a == len - 1) && (b == 3);
            sb.push_back(e);
          end
      end
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin tick(); t++; end
    repeat (4) tick();
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_vld   = 1'b0;
    i_last  = 1'b0;
    tick();
    tick();
    sb.delete();
    i_reset = 1'b0;
    tick();
  endtask

  initial begin
    int f0, o0;
    do_reset();
    check("rst_outs", 128'({o_vld, o_tvalid, o_eob, o_eof, o_blk_idx, o_addr, o_data}), 128'(0));
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_ovf", 128'(o_overflow), 128'(0));

    // 1: four-beat frame with i_last
    f0 = fall_cnt;
    build_frame(0, 0);
    send_frame(4, 1, 0, 0);
    drain();
    check("t1_tvalid_falls", 128'(fall_cnt - f0), 128'(4));

    // 2: two forced-close 64-beat frames back to back
    do_reset();
    f0 = fall_cnt;
    build_frame(1, 1);
    send_frame(64, 0, 0, 0);
    check("t2_ready_bank1", 128'(o_ready), 128'(1));
    build_frame(2, 1);
    send_frame(64, 0, 0, 0);
    drain();
    check("t2_tvalid_falls", 128'(fall_cnt - f0), 128'(8));

    // 3: third frame offered immediately; dropped until bank0 is released
    do_reset();
    o0 = ovf_cnt;
    build_frame(10, 1);
    send_frame(64, 0, 0, 0);
    build_frame(11, 1);
    send_frame(64, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      if (i == 0)   check("t3_ready_low_first", 128'(o_ready), 128'(0));
      if (i == 199) check("t3_ready_low_last", 128'(o_ready), 128'(0));
      i_vld  = 1'b1;
      i_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    i_vld = 1'b0;
    check("t3_ready_after_release", 128'(o_ready), 128'(1));
    build_frame(12, 1);
    send_frame(64, 0, 0, 0);
    check("t3_overflow_count", 128'(ovf_cnt - o0), 128'(200));
    drain();

    // 4: single-beat frame and first-output latency
    do_reset();
    build_frame(20, 0);
    send_frame(1, 1, 0, 0);
    for (int i = 1; i <= RL + 2; i++) begin
      @(negedge i_clk);
      check($sformatf("t4_latency_c%0d", i), 128'(o_vld), 128'(i == RL + 2));
    end
    drain();

    // 5: reset during block 2, then a clean 3-beat frame
    do_reset();
    build_frame(30, 1);
    send_frame(8, 1, 0, 0);
    begin
      int t = 0;
      do begin @(negedge i_clk); t++; end
      while (!(o_vld === 1'b1 && o_blk_idx === 2'd2) && t < 500);
      check("t5_reach_blk2", 128'(o_blk_idx), 128'(2));
    end
    i_reset = 1'b1;
    tick();
    sb.delete();
    i_reset = 1'b0;
    @(negedge i_clk);
    check("t5_vld_after_reset", 128'(o_vld), 128'(0));
    check("t5_ready_after_reset", 128'(o_ready), 128'(1));
    tick();
    build_frame(31, 0);
    send_frame(3, 1, 0, 1);
    drain();

    // 6: random lengths and input gaps, handshaking on o_ready
    do_reset();
    o0 = ovf_cnt;
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 64);
      build_frame(40 + f, 1);
      send_frame(len, (len != 64) || ($urandom_range(0, 1) == 1), 2, 1);
    end
    drain();
    check("t6_no_overflow", 128'(ovf_cnt - o0), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
